// File: rtl/exception_seq.sv
// Multicycle exception sequencer: saves PC-4 into EPC, fetches the handler byte
// at 253/254/255 and loads it into PC while holding the main control in a stall.
module exception_seq #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       check,
    input  logic       bad_opcode,
    input  logic       overflow,
    input  logic       div_zero,
    output logic       busy,
    output logic       done,
    output logic [1:0] exc_cause,
    output logic [7:0] exc_count,
    output logic       EPC_write,
    output logic [1:0] ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [2:0] ALU_op,
    output logic [2:0] iorD,
    output logic       mem_reg_write,
    output logic [1:0] load_ctrl,
    output logic [1:0] PC_src,
    output logic       PC_write
);

    localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CntW-1:0] WaitLoad = CntW'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSaveEpc,
        StAddr,
        StLatch,
        StLoadPc,
        StDone
    } state_e;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseOpcode   = 2'b01;
    localparam logic [1:0] CauseOverflow = 2'b10;
    localparam logic [1:0] CauseDivZero  = 2'b11;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      count_q, count_d;
    logic            req;
    logic [1:0]      req_cause;

    assign req = check & (bad_opcode | overflow | div_zero);

    always_comb begin
        req_cause = CauseNone;
        if (bad_opcode) begin
            req_cause = CauseOpcode;
        end else if (overflow) begin
            req_cause = CauseOverflow;
        end else if (div_zero) begin
            req_cause = CauseDivZero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wait_q  <= '0;
            cause_q <= CauseNone;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Requests are only looked at in IDLE; anything arriving mid-sequence is dropped.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StSaveEpc;
                    cause_d = req_cause;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end
            end
            StSaveEpc: begin
                state_d = StAddr;
                wait_d  = WaitLoad;
            end
            StAddr: begin
                if (wait_q == '0) begin
                    state_d = StLatch;
                end else begin
                    wait_d = wait_q - CntW'(1);
                end
            end
            StLatch:  state_d = StLoadPc;
            StLoadPc: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Handler byte address 253/254/255 follows directly from the cause code.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        EPC_write     = 1'b0;
        ALU_src_A     = 2'b00;
        ALU_src_B     = 2'b00;
        ALU_op        = 3'b000;
        iorD          = 3'b000;
        mem_reg_write = 1'b0;
        load_ctrl     = 2'b00;
        PC_src        = 2'b00;
        PC_write      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StSaveEpc: begin
                busy      = 1'b1;
                EPC_write = 1'b1;
                ALU_src_A = 2'b00;
                ALU_src_B = 2'b01;
                ALU_op    = 3'b010;
            end
            StAddr: begin
                busy = 1'b1;
                iorD = {1'b0, cause_q} + 3'd1;
            end
            StLatch: begin
                busy          = 1'b1;
                iorD          = {1'b0, cause_q} + 3'd1;
                mem_reg_write = 1'b1;
            end
            StLoadPc: begin
                busy      = 1'b1;
                load_ctrl = 2'b10;
                PC_src    = 2'b10;
                PC_write  = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign exc_cause = cause_q;
    assign exc_count = count_q;

    assert property (@(posedge clk) disable iff (reset)
        (iorD != 3'b000) |-> (state_q inside {StAddr, StLatch}));
    assert property (@(posedge clk) disable iff (reset)
        busy |-> (cause_q != CauseNone));
    assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

endmodule

// File: tb/tb_exception_seq.sv
// Scoreboard bench for exception_seq: expected per-cycle output vectors are queued
// at stimulus time and popped by per-DUT monitors on the falling edge.
`timescale 1ns/1ps
module tb_exception_seq;

    localparam int unsigned MW  = 2;
    localparam int unsigned MW1 = 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] cause;
        logic [7:0] count;
        logic       epc_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [2:0] iord;
        logic       mem_reg_write;
        logic [1:0] load_ctrl;
        logic [1:0] pc_src;
        logic       pc_write;
    } obs_t;

    logic clk;
    logic reset;
    logic check, bad_opcode, overflow, div_zero;
    logic check1, bad_opcode1, overflow1, div_zero1;

    logic       busy0, done0, epc0, mrw0, pcw0;
    logic [1:0] cause0, srca0, srcb0, lc0, pcsrc0;
    logic [7:0] count0;
    logic [2:0] aluop0, iord0;
    logic       busy1, done1, epc1, mrw1, pcw1;
    logic [1:0] cause1, srca1, srcb1, lc1, pcsrc1;
    logic [7:0] count1;
    logic [2:0] aluop1, iord1;

    obs_t obs0, obs1;
    obs_t q0[$];
    obs_t q1[$];
    logic [7:0] exp_count [2];
    logic [1:0] exp_cause [2];
    int checks = 0;
    int errors = 0;

    exception_seq #(.MEM_WAIT(MW)) dut0 (
        .clk(clk), .reset(reset), .check(check), .bad_opcode(bad_opcode),
        .overflow(overflow), .div_zero(div_zero), .busy(busy0), .done(done0),
        .exc_cause(cause0), .exc_count(count0), .EPC_write(epc0), .ALU_src_A(srca0),
        .ALU_src_B(srcb0), .ALU_op(aluop0), .iorD(iord0), .mem_reg_write(mrw0),
        .load_ctrl(lc0), .PC_src(pcsrc0), .PC_write(pcw0)
    );

    exception_seq #(.MEM_WAIT(MW1)) dut1 (
        .clk(clk), .reset(reset), .check(check1), .bad_opcode(bad_opcode1),
        .overflow(overflow1), .div_zero(div_zero1), .busy(busy1), .done(done1),
        .exc_cause(cause1), .exc_count(count1), .EPC_write(epc1), .ALU_src_A(srca1),
        .ALU_src_B(srcb1), .ALU_op(aluop1), .iorD(iord1), .mem_reg_write(mrw1),
        .load_ctrl(lc1), .PC_src(pcsrc1), .PC_write(pcw1)
    );

    assign obs0 = {busy0, done0, cause0, count0, epc0, srca0, srcb0, aluop0, iord0, mrw0,
                   lc0, pcsrc0, pcw0};
    assign obs1 = {busy1, done1, cause1, count1, epc1, srca1, srcb1, aluop1, iord1, mrw1,
                   lc1, pcsrc1, pcw1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] iord_of(input logic [1:0] cause);
        case (cause)
            2'b01:   return 3'b010;
            2'b10:   return 3'b011;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push_obs(input int which, input obs_t e);
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // One complete sequence: SAVE_EPC, mw x ADDR, LATCH, LOAD_PC, DONE.
    task automatic push_seq(input int which, input logic [1:0] cause, input int unsigned mw);
        obs_t base, e;
        if (exp_count[which] != 8'hFF) exp_count[which] = exp_count[which] + 8'd1;
        exp_cause[which] = cause;
        base = '0;
        base.busy  = 1'b1;
        base.cause = cause;
        base.count = exp_count[which];
        e = base; e.epc_write = 1'b1; e.src_a = 2'b00; e.src_b = 2'b01; e.alu_op = 3'b010;
        push_obs(which, e);
        for (int i = 0; i < int'(mw); i++) begin
            e = base; e.iord = iord_of(cause);
            push_obs(which, e);
        end
        e = base; e.iord = iord_of(cause); e.mem_reg_write = 1'b1;
        push_obs(which, e);
        e = base; e.load_ctrl = 2'b10; e.pc_src = 2'b10; e.pc_write = 1'b1;
        push_obs(which, e);
        e = base; e.done = 1'b1;
        push_obs(which, e);
    endtask

    task automatic push_idle(input int which, input int n);
        obs_t e;
        e = '0;
        e.cause = exp_cause[which];
        e.count = exp_count[which];
        for (int i = 0; i < n; i++) push_obs(which, e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q0.size(),
                     q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin : monitor0
        obs_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check_obs("seq_mw2", obs0, e);
                end else if (busy0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy_mw2 t=%0t actual=1 required=0", $time);
                end
            end
        end
    end

    initial begin : monitor1
        obs_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check_obs("seq_mw1", obs1, e);
                end else if (busy1) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy_mw1 t=%0t actual=1 required=0", $time);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1;
        check = 1'b0; bad_opcode = 1'b0; overflow = 1'b0; div_zero = 1'b0;
        check1 = 1'b0; bad_opcode1 = 1'b0; overflow1 = 1'b0; div_zero1 = 1'b0;
        exp_count[0] = 8'd0; exp_count[1] = 8'd0;
        exp_cause[0] = 2'b00; exp_cause[1] = 2'b00;
        #1;
        check_obs("reset_mw2", obs0, '0);
        check_obs("reset_mw1", obs1, '0);
        step(); step();
        reset = 1'b0;

        // Single overflow.
        step();
        check = 1'b1; overflow = 1'b1;
        push_seq(0, 2'b10, MW);
        step();
        check = 1'b0; overflow = 1'b0;
        drain(50);
        push_idle(0, 2);
        drain(10);

        // Priority: all three flags -> opcode.
        check = 1'b1; bad_opcode = 1'b1; overflow = 1'b1; div_zero = 1'b1;
        push_seq(0, 2'b01, MW);
        step();
        check = 1'b0; bad_opcode = 1'b0; overflow = 1'b0; div_zero = 1'b0;
        drain(50);
        push_idle(0, 1);
        drain(10);

        // div_zero only.
        check = 1'b1; div_zero = 1'b1;
        push_seq(0, 2'b11, MW);
        step();
        check = 1'b0; div_zero = 1'b0;
        drain(50);
        push_idle(0, 1);
        drain(10);

        // Ignore while busy: overflow pulsed in cycle 3 of a div_zero sequence.
        check = 1'b1; div_zero = 1'b1;
        push_seq(0, 2'b11, MW);
        step();
        check = 1'b0; div_zero = 1'b0;
        step();
        step();
        check = 1'b1; overflow = 1'b1;
        step();
        check = 1'b0; overflow = 1'b0;
        drain(50);
        push_idle(0, 3);
        drain(10);

        // Flags without check.
        bad_opcode = 1'b1; overflow = 1'b1; div_zero = 1'b1;
        push_idle(0, 4);
        drain(10);
        bad_opcode = 1'b0; overflow = 1'b0; div_zero = 1'b0;

        // Asynchronous reset during ADDR.
        check = 1'b1; overflow = 1'b1;
        push_seq(0, 2'b10, MW);
        step();
        check = 1'b0; overflow = 1'b0;
        step();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        q0.delete();
        check_obs("reset_mid_seq", obs0, '0);
        exp_count[0] = 8'd0;
        exp_cause[0] = 2'b00;
        step(); step();
        reset = 1'b0;
        push_idle(0, 2);
        drain(10);

        // Full sequence after reset release.
        check = 1'b1; overflow = 1'b1;
        push_seq(0, 2'b10, MW);
        step();
        check = 1'b0; overflow = 1'b0;
        drain(50);
        push_idle(0, 1);
        drain(10);

        // MEM_WAIT=1 build.
        check1 = 1'b1; bad_opcode1 = 1'b1;
        push_seq(1, 2'b01, MW1);
        step();
        check1 = 1'b0; bad_opcode1 = 1'b0;
        drain(50);
        push_idle(1, 2);
        drain(10);

        // Back-to-back with held request; count saturates at 255.
        check = 1'b1; overflow = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push_seq(0, 2'b10, MW);
            push_idle(0, 1);
        end
        drain(300 * 8 + 50);
        check = 1'b0; overflow = 1'b0;
        push_idle(0, 3);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
